// File: rtl/gpu_inst_decoder.sv
// Registered GPU instruction decoder: validates packed draw words, splits them into draw fields,
// tracks a sticky alpha register. Optional macro DECODE_ERR_CNT_EN enables illegal-word dropping/counting.
module gpu_inst_decoder #(
  parameter int MAX_VERT = 3,
  parameter int VERT_W   = 16,
  parameter int LAYER_W  = 1,
  parameter int COLOR_W  = 24,
  parameter int TEX_W    = 2,
  parameter int ALPHA_W  = 4,
  localparam int VCNT_W  = $clog2(MAX_VERT + 1),
  localparam int INST_W  = 1 + VCNT_W + MAX_VERT*VERT_W + LAYER_W + 1 + COLOR_W + TEX_W + ALPHA_W
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [INST_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MAX_VERT*VERT_W-1:0]   coordinates,
  output logic [VCNT_W-1:0]            vertice_cnt,
  output logic [LAYER_W-1:0]           layer_num,
  output logic                         fill_type,
  output logic [COLOR_W-1:0]           color_code,
  output logic [TEX_W-1:0]             texture_code,
  output logic [ALPHA_W-1:0]           alpha_val,
  output logic [ALPHA_W-1:0]           cur_alpha,
  output logic                         err_illegal,
  output logic [7:0]                   err_count
);

  localparam int COORD_W  = MAX_VERT * VERT_W;
  localparam int VERT_LO  = 1 + VCNT_W;
  localparam int LAYER_LO = VERT_LO + COORD_W;
  localparam int FILL_BIT = LAYER_LO + LAYER_W;
  localparam int COLOR_LO = FILL_BIT + 1;
  localparam int TEX_LO   = COLOR_LO + COLOR_W;
  localparam int ALPHA_LO = TEX_LO + TEX_W;

  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;

  logic                accept, is_alpha, illegal, load;
  logic [VCNT_W-1:0]   raw_vcnt, eff_vcnt;
  logic [COORD_W-1:0]  coords_d;
  logic                fill_d;
  logic [COLOR_W-1:0]  color_d;
  logic [TEX_W-1:0]    tex_d;
  logic [ALPHA_W-1:0]  word_alpha, alpha_d;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign is_alpha  = in_data[0];
  assign load      = accept && !is_alpha && !illegal;

  always_comb begin
    raw_vcnt   = in_data[VCNT_W:1];
    word_alpha = in_data[ALPHA_LO +: ALPHA_W];
    fill_d     = in_data[FILL_BIT];
    illegal    = 1'b0;
    eff_vcnt   = raw_vcnt;
`ifdef DECODE_ERR_CNT_EN
    illegal = (int'(raw_vcnt) < 2) || (int'(raw_vcnt) > MAX_VERT);
`else
    if (int'(raw_vcnt) < 2)             eff_vcnt = VCNT_W'(2);
    else if (int'(raw_vcnt) > MAX_VERT) eff_vcnt = VCNT_W'(MAX_VERT);
`endif
    // Input packs vertex 0 lowest; output places vertex 0 in the MSBs.
    coords_d = '0;
    for (int unsigned i = 0; i < MAX_VERT; i++) begin
      if (i < 32'(eff_vcnt))
        coords_d[(MAX_VERT-1-i)*VERT_W +: VERT_W] = in_data[VERT_LO + i*VERT_W +: VERT_W];
    end
    color_d = fill_d ? '0 : in_data[COLOR_LO +: COLOR_W];
    tex_d   = fill_d ? in_data[TEX_LO +: TEX_W] : '0;
    alpha_d = (word_alpha != '0) ? word_alpha : cur_alpha;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= EMPTY;
      coordinates  <= '0;
      vertice_cnt  <= '0;
      layer_num    <= '0;
      fill_type    <= 1'b0;
      color_code   <= '0;
      texture_code <= '0;
      alpha_val    <= '0;
      cur_alpha    <= '1;
`ifdef DECODE_ERR_CNT_EN
      err_illegal  <= 1'b0;
      err_count    <= '0;
`endif
    end else begin
      if (accept && is_alpha)
        cur_alpha <= in_data[ALPHA_W:1];
      if (load) begin
        state        <= FULL;
        coordinates  <= coords_d;
        vertice_cnt  <= eff_vcnt;
        layer_num    <= in_data[LAYER_LO +: LAYER_W];
        fill_type    <= fill_d;
        color_code   <= color_d;
        texture_code <= tex_d;
        alpha_val    <= alpha_d;
      end else if (out_ready) begin
        state <= EMPTY;
      end
`ifdef DECODE_ERR_CNT_EN
      err_illegal <= accept && !is_alpha && illegal;
      if (accept && !is_alpha && illegal && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
`endif
    end
  end

`ifndef DECODE_ERR_CNT_EN
  assign err_illegal = 1'b0;
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_gpu_inst_decoder.sv
// Self-checking bench for gpu_inst_decoder (default parameters) against a field-level reference model.
module tb_gpu_inst_decoder;
  localparam int MV = 3, VW = 16, LW = 1, CW = 24, TW = 2, AW = 4;
  localparam int VCW = 2, IW = 83, OW = 82;

  logic clk = 1'b0;
  logic n_rst;
  logic [IW-1:0] in_data;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [MV*VW-1:0] coordinates;
  logic [VCW-1:0] vertice_cnt;
  logic [LW-1:0] layer_num;
  logic fill_type;
  logic [CW-1:0] color_code;
  logic [TW-1:0] texture_code;
  logic [AW-1:0] alpha_val, cur_alpha;
  logic err_illegal;
  logic [7:0] err_count;
  logic [OW-1:0] dut_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gpu_inst_decoder #(.MAX_VERT(MV), .VERT_W(VW), .LAYER_W(LW), .COLOR_W(CW), .TEX_W(TW), .ALPHA_W(AW)) dut (
    .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .coordinates(coordinates), .vertice_cnt(vertice_cnt),
    .layer_num(layer_num), .fill_type(fill_type), .color_code(color_code), .texture_code(texture_code),
    .alpha_val(alpha_val), .cur_alpha(cur_alpha), .err_illegal(err_illegal), .err_count(err_count)
  );

  assign dut_out = {coordinates, vertice_cnt, layer_num, fill_type, color_code, texture_code, alpha_val};

  function automatic logic [IW-1:0] mk_draw(input int vc, input logic [15:0] v0, input logic [15:0] v1,
      input logic [15:0] v2, input logic layer, input logic fill, input logic [23:0] color,
      input logic [1:0] tex, input logic [3:0] alpha);
    logic [IW-1:0] w;
    logic [31:0] vcv;
    vcv = vc;
    w = '0;
    w[2:1]   = vcv[1:0];
    w[18:3]  = v0;
    w[34:19] = v1;
    w[50:35] = v2;
    w[51]    = layer;
    w[52]    = fill;
    w[76:53] = color;
    w[78:77] = tex;
    w[82:79] = alpha;
    return w;
  endfunction

  function automatic logic [IW-1:0] mk_alpha(input logic [3:0] a);
    logic [IW-1:0] w;
    w = '0;
    w[36:5]  = $urandom;
    w[68:37] = $urandom;
    w[82:69] = 14'($urandom);
    w[4:1]   = a;
    w[0]     = 1'b1;
    return w;
  endfunction

  function automatic logic [IW-1:0] rand_draw(input int vc, input logic [3:0] alpha);
    return mk_draw(vc, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   24'($urandom), 2'($urandom), alpha);
  endfunction

  // Expected decoded outputs, built from the bit map of the instruction word.
  function automatic logic [OW-1:0] model(input logic [IW-1:0] w, input logic [3:0] ca, output bit legal);
    int vc;
    logic [47:0] co;
    logic [23:0] color;
    logic [1:0] tex;
    logic [3:0] a;
    logic [1:0] vcs;
    vc = int'(w[2:1]);
    legal = (vc >= 2) && (vc <= MV);
`ifndef DECODE_ERR_CNT_EN
    legal = 1'b1;
    if (vc < 2) vc = 2;
    if (vc > MV) vc = MV;
`endif
    co = '0;
    for (int i = 0; i < MV; i++)
      if (i < vc) co[(MV-1-i)*VW +: VW] = w[3 + i*VW +: VW];
    color = w[52] ? 24'h0 : w[76:53];
    tex   = w[52] ? w[78:77] : 2'b00;
    a     = (w[82:79] != 4'h0) ? w[82:79] : ca;
    vcs   = 2'(vc);
    return {co, vcs, w[51], w[52], color, tex, a};
  endfunction

  task automatic do_reset();
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (dut_out !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", dut_out); end
    total++; if (cur_alpha !== 4'hF) begin bad++; $display("FAIL reset_cur_alpha got=%h exp=f", cur_alpha); end
    total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL reset_err_illegal got=%0b exp=0", err_illegal); end
    total++; if (err_count !== 8'h0) begin bad++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_solid_draw();
    logic [IW-1:0] w;
    bit lg;
    w = mk_draw(3, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 24'hFF8000, 2'b11, 4'h5);
    in_data = w; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL solid_out_valid got=%0b exp=1", out_valid); end
    total++; if (color_code !== 24'hFF8000) begin bad++; $display("FAIL solid_color got=%h exp=ff8000", color_code); end
    total++; if (texture_code !== 2'b00) begin bad++; $display("FAIL solid_tex got=%h exp=0", texture_code); end
    total++; if (alpha_val !== 4'h5) begin bad++; $display("FAIL solid_alpha got=%h exp=5", alpha_val); end
    total++; if (dut_out !== model(w, 4'hF, lg)) begin bad++; $display("FAIL solid_all got=%h exp=%h", dut_out, model(w, 4'hF, lg)); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL solid_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_alpha_word();
    logic [IW-1:0] w;
    in_data = mk_alpha(4'h9); in_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL alpha_no_emit got=%0b exp=0", out_valid); end
    total++; if (cur_alpha !== 4'h9) begin bad++; $display("FAIL alpha_cur got=%h exp=9", cur_alpha); end
    w = rand_draw(3, 4'h0);
    in_data = w;
    @(posedge clk); #1 in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL alpha_draw_valid got=%0b exp=1", out_valid); end
    total++; if (alpha_val !== 4'h9) begin bad++; $display("FAIL alpha_inherit got=%h exp=9", alpha_val); end
    total++; if (cur_alpha !== 4'h9) begin bad++; $display("FAIL alpha_sticky got=%h exp=9", cur_alpha); end
  endtask

  task automatic test_texture();
    logic [IW-1:0] w;
    bit lg;
    w = mk_draw(2, 16'hA0A0, 16'hB1B1, 16'hBEEF, 1'b1, 1'b1, 24'h123456, 2'b10, 4'h3);
    in_data = w; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    total++; if (coordinates[15:0] !== 16'h0) begin bad++; $display("FAIL tex_slot2 got=%h exp=0", coordinates[15:0]); end
    total++; if (texture_code !== 2'b10) begin bad++; $display("FAIL tex_code got=%h exp=2", texture_code); end
    total++; if (color_code !== 24'h0) begin bad++; $display("FAIL tex_color got=%h exp=0", color_code); end
    total++; if (vertice_cnt !== 2'd2) begin bad++; $display("FAIL tex_vcnt got=%0d exp=2", vertice_cnt); end
    total++; if (dut_out !== model(w, 4'h9, lg)) begin bad++; $display("FAIL tex_all got=%h exp=%h", dut_out, model(w, 4'h9, lg)); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic [IW-1:0] w;
    bit lg;
    do_reset();
    w = rand_draw(1, 4'h7);
    in_data = w; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
`ifdef DECODE_ERR_CNT_EN
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_dropped got=%0b exp=0", out_valid); end
    total++; if (err_illegal !== 1'b1) begin bad++; $display("FAIL illegal_pulse got=%0b exp=1", err_illegal); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL illegal_count got=%0d exp=1", err_count); end
    @(posedge clk); #1;
    total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse_end got=%0b exp=0", err_illegal); end
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = rand_draw(($urandom_range(0, 1)), 4'($urandom));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (err_count !== 8'd255) begin bad++; $display("FAIL illegal_saturate got=%0d exp=255", err_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_no_emit got=%0b exp=0", out_valid); end
`else
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clamp_emit got=%0b exp=1", out_valid); end
    total++; if (vertice_cnt !== 2'd2) begin bad++; $display("FAIL clamp_vcnt got=%0d exp=2", vertice_cnt); end
    total++; if (dut_out !== model(w, 4'hF, lg)) begin bad++; $display("FAIL clamp_all got=%h exp=%h", dut_out, model(w, 4'hF, lg)); end
    w = rand_draw(0, 4'h0);
    in_data = w; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    total++; if (dut_out !== model(w, 4'hF, lg)) begin bad++; $display("FAIL clamp0_all got=%h exp=%h", dut_out, model(w, 4'hF, lg)); end
    total++; if (err_illegal !== 1'b0 || err_count !== 8'd0) begin bad++; $display("FAIL err_tied got=%0b/%0d exp=0/0", err_illegal, err_count); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] w[3];
    logic [OW-1:0] e[3];
    bit lg;
    int idx_in, idx_out, first_cyc, last_cyc;
    for (int i = 0; i < 3; i++) begin
      w[i] = rand_draw($urandom_range(2, 3), 4'($urandom_range(1, 15)));
      e[i] = model(w[i], 4'hF, lg);
    end
    out_ready = 1'b0; in_valid = 1'b1; in_data = w[0];
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || dut_out !== e[0]) begin bad++; $display("FAIL bp_first got=%0b/%h exp=1/%h", out_valid, dut_out, e[0]); end
    in_data = w[1];
    for (int k = 0; k < 3; k++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || dut_out !== e[0]) begin bad++; $display("FAIL bp_hold got=%0b/%h exp=1/%h", out_valid, dut_out, e[0]); end
    end
    out_ready = 1'b1;
    idx_in = 1; idx_out = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 20 && idx_out < 3; cyc++) begin
      in_valid = (idx_in < 3);
      in_data  = w[idx_in < 3 ? idx_in : 2];
      #1;
      if (out_valid && out_ready) begin
        total++; if (dut_out !== e[idx_out]) begin bad++; $display("FAIL bp_order%0d got=%h exp=%h", idx_out, dut_out, e[idx_out]); end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (idx_out !== 3) begin bad++; $display("FAIL bp_delivered got=%0d exp=3", idx_out); end
    total++; if (last_cyc - first_cyc !== 2) begin bad++; $display("FAIL bp_consecutive got=%0d exp=2", last_cyc - first_cyc); end
  endtask

  task automatic test_random();
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] e;
    logic [IW-1:0] w;
    logic [3:0] ca;
    logic [7:0] cnt;
    bit lg, pulse, have;
    do_reset();
    ca = 4'hF; cnt = 8'd0; have = 1'b0; w = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!have && $urandom_range(0, 4) != 0) begin
        w = ($urandom_range(0, 5) == 0) ? mk_alpha(4'($urandom)) :
            rand_draw($urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom));
        have = 1'b1;
      end
      in_valid  = have;
      in_data   = w;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      pulse = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL rnd_unexpected got=%h exp=none", dut_out);
        end else begin
          e = exp_q.pop_front();
          total++; if (dut_out !== e) begin bad++; $display("FAIL rnd_out got=%h exp=%h", dut_out, e); end
        end
      end
      if (in_valid && in_ready) begin
        have = 1'b0;
        if (w[0]) ca = w[4:1];
        else begin
          e = model(w, ca, lg);
          if (lg) exp_q.push_back(e);
          else begin pulse = 1'b1; if (cnt != 8'hFF) cnt = cnt + 8'd1; end
        end
      end
      @(posedge clk); #1;
      total++; if (cur_alpha !== ca) begin bad++; $display("FAIL rnd_cur_alpha got=%h exp=%h", cur_alpha, ca); end
      total++; if (err_illegal !== pulse) begin bad++; $display("FAIL rnd_err_illegal got=%0b exp=%0b", err_illegal, pulse); end
      total++; if (err_count !== cnt) begin bad++; $display("FAIL rnd_err_count got=%0d exp=%0d", err_count, cnt); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL rnd_drain_extra got=%h exp=none", dut_out);
        end else begin
          e = exp_q.pop_front();
          total++; if (dut_out !== e) begin bad++; $display("FAIL rnd_drain got=%h exp=%h", dut_out, e); end
        end
      end
      @(posedge clk); #1;
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rnd_lost got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    in_data = mk_alpha(4'h6); in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = rand_draw(3, 4'h2);
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || cur_alpha !== 4'h6) begin bad++; $display("FAIL midrst_setup got=%0b/%h exp=1/6", out_valid, cur_alpha); end
    in_data = rand_draw(2, 4'h4);
    #2 n_rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b exp=0", out_valid); end
    total++; if (cur_alpha !== 4'hF) begin bad++; $display("FAIL midrst_alpha got=%h exp=f", cur_alpha); end
    total++; if (dut_out !== '0) begin bad++; $display("FAIL midrst_data got=%h exp=0", dut_out); end
    in_valid = 1'b0; out_ready = 1'b1;
    #1 n_rst = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_after got=%0b exp=0", out_valid); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_solid_draw();
    test_alpha_word();
    test_texture();
    test_illegal();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
